load_store_unit: RTL

Data-memory access stage for the BA20X RV32I core. Consumes the memory-request decode from the control path (request type, size mask, signedness) and the address and store data from the datapath. It runs a valid/ready request plus response handshake on the data bus and returns aligned, extended load data to writeback. It holds the single-cycle core stalled until the access completes.

---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-bus interface for load_store_unit: a valid/ready request channel and
// a response/write-ack beat channel.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  bus_req_valid;
  logic                  bus_req_ready;
  logic                  bus_req_write;
  logic [ADDR_WIDTH-1:0] bus_req_addr;
  logic [3:0]            bus_req_strb;
  logic [31:0]           bus_req_wdata;
  logic                  bus_resp_valid;
  logic [31:0]           bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_write, bus_req_addr, bus_req_strb, bus_req_wdata,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_write, bus_req_addr, bus_req_strb, bus_req_wdata,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I data-memory access stage: issues one bus request per load/store and stalls the core until done.
// Optional build macro LSU_MISALIGN_TRAP_EN: flag misaligned accesses instead of forcing alignment.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_type,
  input  logic [3:0]            req_wmask,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  load_store_unit_if.master     bus
);
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
   localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;

   state_e                state_q, state_d;
   logic                  capture;
   logic [1:0]            size_c, lane_c;
   logic [3:0]            mask_c;
   logic [31:0]           wdata_c;
   logic                  go_c;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  write_q, uns_q;
   logic [3:0]            strb_q;
   logic [31:0]           wdata_q, rdata_q;
   logic [1:0]            size_q, lane_q;

   // Unknown masks are treated as word accesses.
   always_comb begin
      size_c = SZ_W;
      case (req_wmask)
         4'b0001: size_c = SZ_B;
         4'b0011: size_c = SZ_H;
         default: size_c = SZ_W;
      endcase
   end

   // Low address bits forced to natural alignment before lane selection.
   always_comb begin
      lane_c  = 2'b00;
      mask_c  = 4'b1111;
      wdata_c = req_wdata;
      case (size_c)
         SZ_B: begin
            lane_c  = req_addr[1:0];
            mask_c  = 4'b0001;
            wdata_c = {4{req_wdata[7:0]}};
         end
         SZ_H: begin
            lane_c  = {req_addr[1], 1'b0};
            mask_c  = 4'b0011;
            wdata_c = {2{req_wdata[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_c;
   assign mis_c      = ((size_c == SZ_H) && req_addr[0]) ||
                       ((size_c == SZ_W) && (req_addr[1:0] != 2'b00));
   assign misaligned = (state_q == IDLE) && req_valid && mis_c;
   assign go_c       = !mis_c;
`else
   assign misaligned = 1'b0;
   assign go_c       = 1'b1;
`endif

   assign stall = req_valid && (state_q != DONE) && !misaligned;

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         IDLE: if (req_valid && go_c) begin
            state_d = REQ;
            capture = 1'b1;
         end
         REQ:  if (bus.bus_req_ready)  state_d = WAIT;
         WAIT: if (bus.bus_resp_valid) state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         strb_q  <= 4'b0;
         wdata_q <= 32'b0;
         rdata_q <= 32'b0;
         size_q  <= SZ_B;
         lane_q  <= 2'b00;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
            write_q <= req_type;
            uns_q   <= req_unsigned;
            strb_q  <= mask_c << lane_c;
            wdata_q <= wdata_c;
            size_q  <= size_c;
            lane_q  <= lane_c;
         end
         if (state_q == WAIT && bus.bus_resp_valid) rdata_q <= bus.bus_resp_rdata;
      end
   end

   assign bus.bus_req_valid = (state_q == REQ);
   assign bus.bus_req_write = write_q;
   assign bus.bus_req_addr  = addr_q;
   assign bus.bus_req_strb  = strb_q;
   assign bus.bus_req_wdata = wdata_q;

   logic [7:0]  byte_c;
   logic [15:0] half_c;
   logic [31:0] ext_c;

   always_comb begin
      byte_c = rdata_q[7:0];
      case (lane_q)
         2'd1:    byte_c = rdata_q[15:8];
         2'd2:    byte_c = rdata_q[23:16];
         2'd3:    byte_c = rdata_q[31:24];
         default: byte_c = rdata_q[7:0];
      endcase
      half_c = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (size_q)
         SZ_B:    ext_c = {{24{byte_c[7] & ~uns_q}}, byte_c};
         SZ_H:    ext_c = {{16{half_c[15] & ~uns_q}}, half_c};
         default: ext_c = rdata_q;
      endcase
   end

   assign load_data = (state_q == DONE) ? ext_c : 32'b0;
endmodule
